// File: rtl/frame_scan_pkg.sv
// Shared geometry, colour-bit positions, direction codes and FSM encoding for the frame scanner.
package frame_scan_pkg;

    localparam int C_IMG_COLS    = 80;
    localparam int C_IMG_ROWS    = 60;
    localparam int C_NB_IMG_PXLS = 13;
    localparam int C_NB_COL      = 7;
    localparam int C_NB_BUF      = 12;
    localparam int C_MIN_PXLS    = 16;
    localparam int C_NB_PXLS     = C_IMG_COLS * C_IMG_ROWS;

    localparam int C_RED_MSB = 11;
    localparam int C_GRN_MSB = 7;
    localparam int C_BLU_MSB = 3;

    localparam logic [C_NB_IMG_PXLS-1:0] C_LAST_ADDR     = C_NB_IMG_PXLS'(C_NB_PXLS - 1);
    localparam logic [C_NB_COL-1:0]      C_LAST_COL      = C_NB_COL'(C_IMG_COLS - 1);
    localparam logic [C_NB_COL-1:0]      C_HALF_COL      = C_NB_COL'(C_IMG_COLS / 2);
    localparam logic [C_NB_COL-1:0]      C_THIRD_COL     = C_NB_COL'(C_IMG_COLS / 3);
    localparam logic [C_NB_COL-1:0]      C_TWO_THIRD_COL = C_NB_COL'((2 * C_IMG_COLS) / 3);

    typedef enum logic [1:0] {
        DIR_NONE   = 2'b00,
        DIR_LEFT   = 2'b01,
        DIR_RIGHT  = 2'b10,
        DIR_CENTRE = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic dir_t decide_halves(input logic [C_NB_IMG_PXLS-1:0] left,
                                           input logic [C_NB_IMG_PXLS-1:0] right);
        logic [C_NB_IMG_PXLS:0] total;
        total = {1'b0, left} + {1'b0, right};
        if (total < (C_NB_IMG_PXLS + 1)'(C_MIN_PXLS)) return DIR_NONE;
        if (left > right) return DIR_LEFT;
        if (right > left) return DIR_RIGHT;
        return DIR_CENTRE;
    endfunction

    // Ties between the largest zones go to left first, then right.
    function automatic dir_t decide_thirds(input logic [C_NB_IMG_PXLS-1:0] left,
                                           input logic [C_NB_IMG_PXLS-1:0] centre,
                                           input logic [C_NB_IMG_PXLS-1:0] right);
        logic [C_NB_IMG_PXLS+1:0] total;
        total = {2'b00, left} + {2'b00, centre} + {2'b00, right};
        if (total < (C_NB_IMG_PXLS + 2)'(C_MIN_PXLS)) return DIR_NONE;
        if (left >= right && left >= centre) return DIR_LEFT;
        if (right >= centre) return DIR_RIGHT;
        return DIR_CENTRE;
    endfunction

endpackage

// File: rtl/pxl_hit_filter.sv
// Combinational colour classifier: a pixel hits when every selected channel has its MSB set.
module pxl_hit_filter
    import frame_scan_pkg::*;
(
    input  logic [C_NB_BUF-1:0] pxl,
    input  logic [2:0]          rgbfilter,
    output logic                hit
);

    logic [8:0] pxl_unused;

    assign pxl_unused = {pxl[10:8], pxl[6:4], pxl[2:0]};

    always_comb begin
        hit = (rgbfilter != 3'b000)
            && (!rgbfilter[2] || pxl[C_RED_MSB])
            && (!rgbfilter[1] || pxl[C_GRN_MSB])
            && (!rgbfilter[0] || pxl[C_BLU_MSB]);
    end

endmodule

// File: rtl/frame_scan_ctrl.sv
// Walks the frame buffer once per request, counts colour hits per zone and decides a steering direction.
// Optional three-zone split (left/centre/right, extra cnt_centre port) when SCAN_CENTRE_EN is defined.
module frame_scan_ctrl
    import frame_scan_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               rgbfilter,
    input  logic [C_NB_BUF-1:0]      orig_pxl,
    output logic [C_NB_IMG_PXLS-1:0] orig_addr,
    output logic                     proc_we,
    output logic [C_NB_IMG_PXLS-1:0] proc_addr,
    output logic                     busy,
    output logic                     done,
    output logic [C_NB_IMG_PXLS-1:0] cnt_left,
    output logic [C_NB_IMG_PXLS-1:0] cnt_right,
`ifdef SCAN_CENTRE_EN
    output logic [C_NB_IMG_PXLS-1:0] cnt_centre,
`endif
    output logic [1:0]               dir,
    output logic [7:0]               leds
);

    state_t                   state;
    state_t                   state_nxt;
    logic [C_NB_COL-1:0]      col;
    logic [C_NB_COL-1:0]      col_d;
    logic                     valid_d;
    logic                     hit;
    logic                     done_sticky;
    logic                     zone_left;
    logic                     zone_right;
    logic [C_NB_IMG_PXLS-1:0] acc_left;
    logic [C_NB_IMG_PXLS-1:0] acc_right;
    dir_t                     dir_nxt;
`ifdef SCAN_CENTRE_EN
    logic                     zone_centre;
    logic [C_NB_IMG_PXLS-1:0] acc_centre;
`endif

    pxl_hit_filter u_hit_filter (
        .pxl       (orig_pxl),
        .rgbfilter (rgbfilter),
        .hit       (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start is a level request with no ready: it is only looked at in IDLE, ignored elsewhere.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SCAN;
            ST_SCAN:   if (orig_addr == C_LAST_ADDR) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SCAN) || (state == ST_DRAIN) || (state == ST_DECIDE);
        done = (state == ST_DONE);
    end

    // Address generation; column and valid are delayed one cycle to line up with orig_pxl.
    always_ff @(posedge clk) begin
        if (!rst) begin
            orig_addr <= '0;
            col       <= '0;
            col_d     <= '0;
            valid_d   <= 1'b0;
            proc_addr <= '0;
        end else begin
            col_d     <= col;
            valid_d   <= (state == ST_SCAN);
            proc_addr <= orig_addr;
            if (state == ST_IDLE && start) begin
                orig_addr <= '0;
                col       <= '0;
            end else if (state == ST_SCAN && orig_addr != C_LAST_ADDR) begin
                orig_addr <= orig_addr + 1'b1;
                col       <= (col == C_LAST_COL) ? '0 : col + 1'b1;
            end
        end
    end

    assign proc_we = valid_d;

    always_comb begin
`ifdef SCAN_CENTRE_EN
        zone_left   = (col_d < C_THIRD_COL);
        zone_right  = (col_d >= C_TWO_THIRD_COL);
        zone_centre = !zone_left && !zone_right;
`else
        zone_left   = (col_d < C_HALF_COL);
        zone_right  = !zone_left;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst || state == ST_DONE) begin
            acc_left   <= '0;
            acc_right  <= '0;
`ifdef SCAN_CENTRE_EN
            acc_centre <= '0;
`endif
        end else if (valid_d && hit) begin
            if (zone_left)  acc_left  <= acc_left + 1'b1;
            if (zone_right) acc_right <= acc_right + 1'b1;
`ifdef SCAN_CENTRE_EN
            if (zone_centre) acc_centre <= acc_centre + 1'b1;
`endif
        end
    end

    always_comb begin
`ifdef SCAN_CENTRE_EN
        dir_nxt = decide_thirds(acc_left, acc_centre, acc_right);
`else
        dir_nxt = decide_halves(acc_left, acc_right);
`endif
    end

    // Results hold until the next frame completes; done_sticky survives until a new scan starts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_left    <= '0;
            cnt_right   <= '0;
            dir         <= DIR_NONE;
            done_sticky <= 1'b0;
`ifdef SCAN_CENTRE_EN
            cnt_centre  <= '0;
`endif
        end else begin
            if (state == ST_IDLE && start) done_sticky <= 1'b0;
            if (state == ST_DECIDE) begin
                cnt_left    <= acc_left;
                cnt_right   <= acc_right;
                dir         <= dir_nxt;
                done_sticky <= 1'b1;
`ifdef SCAN_CENTRE_EN
                cnt_centre  <= acc_centre;
`endif
            end
        end
    end

    assign leds = {dir, busy, done_sticky, 4'b0000};

endmodule
